jtcps2_keyload_seq: RTL and testbench

//  Parametrised CPS2 decryption-key loader. Captures the key blob from the ROM download stream

---
 rtl/jtcps2_keyload_pkg.sv | 24 ++
 rtl/jtcps2_keyload_seq_if.sv | 31 +++
 rtl/jtcps2_keyload_perm.sv | 30 +++
 rtl/jtcps2_keyload_seq.sv | 144 ++++++++++++++
 tb/tb_jtcps2_keyload_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/jtcps2_keyload_pkg.sv
// Shared types and helpers for the CPS2 key loader: signature constants,
// load FSM states and the cfg word source mapping.
package jtcps2_keyload_pkg;

  localparam logic [7:0]  SUM_MASK = 8'hCF;
  localparam logic [11:0] SUM_XOR  = 12'h065;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    OVF  = 2'd3
  } state_t;

  // Source word j for cfg word p (p=0 is the most significant word). Words
  // inside the key region are swapped in pairs; everything above is identity.
  function automatic int word_src(input int p, input int nwords, input int key_w);
    int kbase;
    kbase = nwords - key_w / 16;
    if (p < kbase) return p;
    return kbase + ((p - kbase) ^ 1);
  endfunction

endpackage

// File: rtl/jtcps2_keyload_seq_if.sv
// Download stream in, decrypt key/range out. The master side is the ROM
// download logic, the slave side is the key loader.
interface jtcps2_keyload_seq_if #(
  parameter int NWORDS = 10,
  parameter int KEY_W  = 64,
  parameter int RNG_W  = 16
) ();

  localparam int CNT_W = $clog2(2 * NWORDS + 1);

  logic              din_start;
  logic [7:0]        din;
  logic              din_we;
  logic              key_vld;
  logic              key_ovf;
  logic [CNT_W-1:0]  byte_cnt;
  logic [11:0]       sum;
  logic [RNG_W-1:0]  addr_rng;
  logic [KEY_W-1:0]  key;

  modport master (
    output din_start, din, din_we,
    input  key_vld, key_ovf, byte_cnt, sum, addr_rng, key
  );

  modport slave (
    input  din_start, din, din_we,
    output key_vld, key_ovf, byte_cnt, sum, addr_rng, key
  );

endinterface

// File: rtl/jtcps2_keyload_perm.sv
// Pure combinational bit permutation of the captured blob into the cfg words
// consumed by the CPU decrypter.
module jtcps2_keyload_perm #(
  parameter int NWORDS = 10,
  parameter int KEY_W  = 64
) (
  input  logic [16*NWORDS-1:0] raw,
  output logic [16*NWORDS-1:0] cfg
);
  import jtcps2_keyload_pkg::*;

  localparam int N = 16 * NWORDS;

  // Raw bit feeding position k (k=0 is the word MSB) of a word sourced from j.
  // The last two positions borrow the low bits of the previous byte, wrapping.
  function automatic int raw_idx(input int j, input int k);
    if (k < 6)   return 16 * j + 10 + k;
    if (k < 14)  return 16 * j + (k - 6);
    if (k == 14) return (16 * j - 8 + N) % N;
    return (16 * j - 7 + N) % N;
  endfunction

  for (genvar p = 0; p < NWORDS; p++) begin : g_word
    localparam int J = word_src(p, NWORDS, KEY_W);
    for (genvar k = 0; k < 16; k++) begin : g_bit
      assign cfg[N-1-16*p-k] = raw[raw_idx(J, k)];
    end
  end

endmodule

// File: rtl/jtcps2_keyload_seq.sv
// CPS2 decryption-key loader: captures the key blob from the download stream,
// keeps a running signature, and presents the permuted key/range once the
// whole blob has arrived.
module jtcps2_keyload_seq
  import jtcps2_keyload_pkg::*;
#(
  parameter int NWORDS = 10,
  parameter int KEY_W  = 64,
  parameter int RNG_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtcps2_keyload_seq_if.slave  bus
);

  localparam int N      = 16 * NWORDS;
  localparam int NBYTES = 2 * NWORDS;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  state_t            state, state_nxt;
  logic              last_we;
  logic              wr_ev;
  logic              capture;
  logic              set_ovf;
  logic [N-1:0]      raw;
  logic [N-9:0]      raw_keep;
  logic [11:0]       sum;
  logic [11:0]       sum_keep;
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  cnt_keep;
  logic              key_vld;
  logic              key_ovf;
  logic [N-1:0]      cfg;
  logic              unused_cfg;

  // Signature step: conditional XOR, then add the sign-extended byte mod 4096.
  function automatic logic [11:0] sig_step(input logic [11:0] s, input logic [7:0] d);
    logic signed [11:0] d_ext;
    logic [11:0]        base;
    d_ext = {{4{d[7]}}, d};
    base  = ((d & SUM_MASK) != 8'h00) ? (s ^ SUM_XOR) : s;
    return base + unsigned'(d_ext);
  endfunction

  assign wr_ev = bus.din_we & ~last_we;

  // A start pulse discards the old blob before any same-cycle byte is taken.
  assign raw_keep = bus.din_start ? '0 : raw[N-1:8];
  assign sum_keep = bus.din_start ? '0 : sum;
  assign cnt_keep = bus.din_start ? '0 : byte_cnt;

  // Load FSM next state and capture/overflow decisions.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    set_ovf   = 1'b0;
    if (bus.din_start) begin
      capture   = wr_ev;
      state_nxt = wr_ev ? LOAD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ev) begin
            capture   = 1'b1;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          if (wr_ev) begin
            capture = 1'b1;
            if (byte_cnt == LAST_CNT) state_nxt = DONE;
          end
        end
        DONE: begin
          if (wr_ev) begin
            set_ovf   = 1'b1;
            state_nxt = OVF;
          end
        end
        OVF: begin
          set_ovf = wr_ev;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobe edge tracking and status flags; key_vld lags DONE by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_we <= 1'b0;
      key_vld <= 1'b0;
      key_ovf <= 1'b0;
    end else begin
      last_we <= bus.din_we;
      key_vld <= ~bus.din_start & ((state == DONE) | (state == OVF));
      if (bus.din_start)  key_ovf <= 1'b0;
      else if (set_ovf)   key_ovf <= 1'b1;
    end
  end

  // Blob shift register, signature and byte count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw      <= '0;
      sum      <= '0;
      byte_cnt <= '0;
    end else if (capture) begin
      raw      <= {bus.din, raw_keep};
      sum      <= sig_step(sum_keep, bus.din);
      byte_cnt <= cnt_keep + CNT_W'(1);
    end else if (bus.din_start) begin
      raw      <= '0;
      sum      <= '0;
      byte_cnt <= '0;
    end
  end

  jtcps2_keyload_perm #(
    .NWORDS (NWORDS),
    .KEY_W  (KEY_W)
  ) u_perm (
    .raw (raw),
    .cfg (cfg)
  );

  // The middle cfg words are not routed anywhere in this configuration.
  assign unused_cfg = ^cfg;

  assign bus.key_vld  = key_vld;
  assign bus.key_ovf  = key_ovf;
  assign bus.byte_cnt = byte_cnt;
  assign bus.sum      = sum;
  assign bus.key      = key_vld ? cfg[KEY_W-1:0] : '0;
  assign bus.addr_rng = key_vld ? cfg[N-1 -: RNG_W] : '0;

endmodule

// File: tb/tb_jtcps2_keyload_seq.sv
// Directed bench for the CPS2 key loader.
module tb_jtcps2_keyload_seq;

  localparam int NWORDS = 10;
  localparam int KEY_W  = 64;
  localparam int RNG_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jtcps2_keyload_seq_if #(.NWORDS(NWORDS), .KEY_W(KEY_W), .RNG_W(RNG_W)) bus ();

  jtcps2_keyload_seq #(.NWORDS(NWORDS), .KEY_W(KEY_W), .RNG_W(RNG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    bus.din    = d;
    bus.din_we = 1'b1;
    @(negedge clk);
    bus.din_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pat(input int sel, input int i);
    case (sel)
      0: return (i == 0) ? 8'h01 : 8'h00;
      1: return (i == 19) ? 8'h80 : 8'h00;
      2: return (i == 0) ? 8'h01 : ((i == 19) ? 8'h80 : 8'h00);
      3: return (i == 12 || i == 13) ? 8'h01 : ((i == 19) ? 8'h03 : 8'h00);
      default: return 8'h11;
    endcase
  endfunction

  task automatic load(input int sel, input int n);
    for (int i = 0; i < n; i++) wr(pat(sel, i));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".key_vld"},  64'(bus.key_vld),  64'd0);
    chk({tag, ".key_ovf"},  64'(bus.key_ovf),  64'd0);
    chk({tag, ".byte_cnt"}, 64'(bus.byte_cnt), 64'd0);
    chk({tag, ".sum"},      64'(bus.sum),      64'd0);
    chk({tag, ".addr_rng"}, 64'(bus.addr_rng), 64'd0);
    chk({tag, ".key"},      bus.key,           64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.din_start = 1'b0;
    bus.din       = 8'h00;
    bus.din_we    = 1'b0;
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;

    // single signed byte and a byte that skips the XOR
    wr(8'h80);
    chk("t1.sum80", 64'(bus.sum), 64'h0FE5);
    chk("t1.cnt", 64'(bus.byte_cnt), 64'd1);
    chk("t1.vld", 64'(bus.key_vld), 64'd0);
    chk("t1.key", bus.key, 64'd0);
    do_reset();
    wr(8'h30);
    chk("t1.sum30", 64'(bus.sum), 64'h030);

    // full load, byte0 = 01: lands in the range word
    do_reset();
    load(0, 20);
    chk("t2.vld_lag", 64'(bus.key_vld), 64'd0);
    tick(1);
    chk("t2.vld", 64'(bus.key_vld), 64'd1);
    chk("t2.cnt", 64'(bus.byte_cnt), 64'd20);
    chk("t2.rng", 64'(bus.addr_rng), 64'h0200);
    chk("t2.key", bus.key, 64'd0);
    chk("t2.sum", 64'(bus.sum), 64'h066);
    chk("t2.ovf", 64'(bus.key_ovf), 64'd0);

    // full load, byte19 = 80: lands in a swapped key word
    do_reset();
    load(1, 20);
    tick(1);
    chk("t2b.key", bus.key, 64'h0000_0000_0400_0000);
    chk("t2b.rng", 64'(bus.addr_rng), 64'h0000);
    chk("t2b.sum", 64'(bus.sum), 64'hFE5);

    // wrap-around bits and both key pair swaps
    do_reset();
    load(3, 20);
    tick(1);
    chk("t2c.key", bus.key, 64'h0002_0200_0000_0000);
    chk("t2c.rng", 64'(bus.addr_rng), 64'h0003);
    chk("t2c.sum", 64'(bus.sum), 64'h064);

    // long strobe gives one capture
    do_reset();
    @(negedge clk);
    bus.din    = 8'h55;
    bus.din_we = 1'b1;
    tick(6);
    bus.din_we = 1'b0;
    tick(1);
    chk("t3.cnt", 64'(bus.byte_cnt), 64'd1);
    chk("t3.sum", 64'(bus.sum), 64'h0BA);

    // overflow byte after a complete blob
    do_reset();
    load(1, 20);
    wr(8'hFF);
    chk("t4.ovf", 64'(bus.key_ovf), 64'd1);
    chk("t4.vld", 64'(bus.key_vld), 64'd1);
    chk("t4.key", bus.key, 64'h0000_0000_0400_0000);
    chk("t4.sum", 64'(bus.sum), 64'hFE5);
    chk("t4.cnt", 64'(bus.byte_cnt), 64'd20);
    wr(8'hFF);
    chk("t4.ovf2", 64'(bus.key_ovf), 64'd1);
    chk("t4.cnt2", 64'(bus.byte_cnt), 64'd20);

    // restart mid-load, then a fresh full load
    do_reset();
    load(4, 7);
    chk("t5.cnt7", 64'(bus.byte_cnt), 64'd7);
    @(negedge clk);
    bus.din_start = 1'b1;
    @(negedge clk);
    bus.din_start = 1'b0;
    chk("t5.cnt", 64'(bus.byte_cnt), 64'd0);
    chk("t5.sum", 64'(bus.sum), 64'd0);
    chk("t5.vld", 64'(bus.key_vld), 64'd0);
    load(2, 20);
    tick(1);
    chk("t5.rng", 64'(bus.addr_rng), 64'h0200);
    chk("t5.key", bus.key, 64'h0000_0000_0400_0000);
    chk("t5.sum2", 64'(bus.sum), 64'hF83);
    chk("t5.cnt2", 64'(bus.byte_cnt), 64'd20);

    // start coincident with a write: byte becomes byte 0
    @(negedge clk);
    bus.din_start = 1'b1;
    bus.din       = 8'hAA;
    bus.din_we    = 1'b1;
    @(negedge clk);
    bus.din_start = 1'b0;
    bus.din_we    = 1'b0;
    chk("t5c.cnt", 64'(bus.byte_cnt), 64'd1);
    chk("t5c.sum", 64'(bus.sum), 64'h00F);
    chk("t5c.vld", 64'(bus.key_vld), 64'd0);
    chk("t5c.key", bus.key, 64'd0);

    // reset mid-load
    do_reset();
    load(4, 12);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("t6");
    rst_n = 1'b1;
    load(2, 20);
    tick(1);
    chk("t6.vld", 64'(bus.key_vld), 64'd1);
    chk("t6.rng", 64'(bus.addr_rng), 64'h0200);
    chk("t6.key", bus.key, 64'h0000_0000_0400_0000);
    chk("t6.sum", 64'(bus.sum), 64'hF83);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
